// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_muxn and its output skid buffer.
package pipe_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Skid-buffer occupancy. Bit 1 = main_valid, bit 0 = skid_valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } buf_state_t;

    // Ceiling log2. A value of at least 1 keeps a 1-bit select for tiny muxes.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// 2-entry valid/ready skid buffer. in_ready comes from registers and rst
// only, so downstream ready never reaches upstream combinationally.
module skid_buf2
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         acc, xfer;

    assign out_valid = state_q[1];
    assign in_ready  = !rst && !state_q[0];
    assign out_data  = main_q;
    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // Next-state and datapath moves for the EMPTY/ONE/FULL occupancy machine.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && xfer) begin
                    main_d = in_data;
                end else if (acc) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path applies.
                if (xfer) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipe_muxn.sv
// N-way registered select mux with valid/ready output skid buffer.
// Optional sticky out-of-range select flag: define PIPE_MUXN_SEL_ERR_EN.
module pipe_muxn
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = DATA_W_DEFAULT,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    sel_err
);

    logic [WIDTH-1:0]       sel_data;
    logic                   sel_hit;
    logic                   oob;
    logic [WIDTH+SEL_W-1:0] buf_out;

    // Channel select; selects with no matching channel yield zero.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    assign oob = !sel_hit;

    skid_buf2 #(.W(WIDTH + SEL_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({sel_data, in_sel}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = buf_out[WIDTH+SEL_W-1:SEL_W];
    assign out_chan = buf_out[SEL_W-1:0];

`ifdef PIPE_MUXN_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky error: clear first, so a same-edge new error wins.
    always_comb begin
        sel_err_d = sel_err_q;
        if (err_clr) sel_err_d = 1'b0;
        if (in_valid && in_ready && oob) sel_err_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`else
    logic unused_err;
    assign unused_err = err_clr ^ oob;
    assign sel_err    = 1'b0;
`endif

endmodule

// File: doc/pipe_muxn.md
Name: pipe_muxn

Overview:
- Parametrised N-way, WIDTH-bit registered select mux. It is the successor to the datapath 2:1 operand mux.
- A valid/ready handshake and a 2-entry skid buffer sit on the output, so the block can be placed between pipeline stages (e.g. ALU operand forwarding select, writeback source select) without breaking the ready path.
- Latency is 1 cycle. Throughput is 1 transfer per cycle.

Parameters:
- WIDTH, 32, data width of each input channel and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, derived localparam = clog2(NUM_IN), width of the select field. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  channel index
- in_valid  in  1  upstream has data
- in_ready  out  1  block can accept data
- out_data  out  WIDTH  selected data, registered
- out_chan  out  SEL_W  in_sel value that produced out_data
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts
- err_clr  in  1  clears sel_err
- sel_err  out  1  sticky out-of-range select flag

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_chan=0, sel_err=0.
  - skid register empty, skid data=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-transfer drops all buffered data and does not replay it.
- Accept rule: a transfer happens when in_valid && in_ready at a rising edge.
  - Selected value: in_data[in_sel*WIDTH +: WIDTH].
  - If in_sel >= NUM_IN, the selected value is all-zero. The transfer still completes normally.
- Output transfer: a transfer happens when out_valid && out_ready at a rising edge.
- in_ready = !rst && !skid_valid. It is driven from registers only, with no combinational path from out_ready.
- State (main_valid, skid_valid):
  - EMPTY (0,0): an accepted input loads main; go to ONE.
  - ONE (1,0):
    - accept + output transfer: main reloads with the new value; stay in ONE.
    - accept, no output transfer: new value goes to skid; go to FULL.
    - output transfer, no accept: go to EMPTY.
    - neither: hold.
  - FULL (1,1): in_ready=0.
    - output transfer: skid moves to main, skid clears; go to ONE. in_ready rises the next cycle.
    - otherwise hold.
- Data ordering: strict FIFO order. No beat is lost or duplicated under any out_ready pattern.
- out_data and out_chan must not change while out_valid=1 and out_ready=0.
- in_data and in_sel are sampled only on the accept edge and may change freely at other times.

Optional Feature:
- Macro: PIPE_MUXN_SEL_ERR_EN.
- Defined:
  - sel_err sets on any accepted transfer with in_sel >= NUM_IN and stays set until err_clr=1 or rst.
  - If err_clr and a new error occur on the same edge, set wins.
- Undefined: sel_err is tied to 0 and err_clr is ignored. The all-zero data rule for out-of-range selects still applies.
- When NUM_IN is a power of two, sel_err never sets.

Decomposition:
- Shared package/include pipe_pkg:
  - DATA_W_DEFAULT=32.
  - clog2 constant function.
  - State encodings EMPTY/ONE/FULL.
- Sub-module: skid_buf2, a WIDTH+SEL_W-wide 2-entry valid/ready skid buffer.
- pipe_muxn = combinational selector + error logic feeding skid_buf2.

Test Plan:
- Reset and basic transfer:
  - Stimulus: hold rst for 2 cycles; WIDTH=32, NUM_IN=4, in_data ch2=32'hDEADBEEF, in_sel=2, in_valid=1 for 1 cycle, out_ready=1.
  - Response: out_data=32'hDEADBEEF and out_chan=2 with out_valid=1 exactly 1 cycle after the accept. out_valid=0 during reset.
- Streaming:
  - Stimulus: 16 back-to-back beats cycling sel 0..3, out_ready=1.
  - Response: in_ready stays 1; 16 outputs in order with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0, push beats A then B.
  - Response: state reaches FULL; in_ready=0 the cycle after B is accepted. A is held stable on the output.
  - Then raise out_ready for 1 cycle: A leaves, B moves to main, in_ready=1 the next cycle. No third beat is accepted while FULL.
- Random stall:
  - Stimulus: 1000 beats, random in_valid and out_ready.
  - Response: a scoreboard sees every beat exactly once, in order.
- Out-of-range select:
  - Stimulus: NUM_IN=3, in_sel=3.
  - Response: out_data=0.
  - With PIPE_MUXN_SEL_ERR_EN: sel_err=1 the cycle after the accept, held until an err_clr pulse. Simultaneous err_clr plus error leaves sel_err=1.
  - Without the macro: sel_err stays 0.
- Reset mid-operation:
  - Stimulus: assert rst while in FULL.
  - Response: out_valid=0 and in_ready=0 during reset; no stale beat appears after deassertion.
